// File: rtl/toggle_activity_monitor_pkg.sv
// Shared types and width helpers for the toggle activity monitor.
package pwr_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_RUN  = 2'd2
    } mon_state_e;

    // Input-toggle total: a full window of NUM_IN-bit popcounts fits in CNT_W plus the popcount width.
    function automatic int tot_width(input int cnt_w, input int num_in);
        return cnt_w + $clog2(num_in + 1);
    endfunction

endpackage

// File: rtl/toggle_activity_monitor_if.sv
// Sample stream from the observed cell plus the per-window report handshake.
interface toggle_activity_monitor_if #(
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = 8,
    parameter int TOT_W  = pwr_mon_pkg::tot_width(CNT_W, NUM_IN)
);
    logic              in_valid;
    logic [NUM_IN-1:0] in_vec;
    logic              in_out;
    logic              rpt_valid;
    logic              rpt_ready;
    logic [TOT_W-1:0]  rpt_in_tog;
    logic [CNT_W-1:0]  rpt_out_tog;
    logic [IDX_W-1:0]  rpt_win_idx;

    modport mon (
        input  in_valid, in_vec, in_out, rpt_ready,
        output rpt_valid, rpt_in_tog, rpt_out_tog, rpt_win_idx
    );

    modport master (
        output in_valid, in_vec, in_out, rpt_ready,
        input  rpt_valid, rpt_in_tog, rpt_out_tog, rpt_win_idx
    );
endinterface

// File: rtl/toggle_activity_monitor_popcount.sv
// Combinational population count of an N-bit vector.
module popcount_n #(
    parameter int N = 4,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] bits_i,
    output logic [W-1:0] cnt_o
);
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < N; i++) begin
            cnt_o = cnt_o + W'(bits_i[i]);
        end
    end
endmodule

// File: rtl/toggle_activity_monitor.sv
// Windowed switching-activity counter for a small combinational cell.
//   state | meaning
//   IDLE  | not counting; samples ignored
//   SEED  | waiting for the first sample to load the previous-sample register
//   RUN   | counting toggles between consecutive samples, reporting every WIN_LEN transitions
module toggle_activity_monitor
    import pwr_mon_pkg::*;
#(
    parameter int NUM_IN  = 4,
    parameter int WIN_LEN = 256,
    parameter int CNT_W   = 16,
    parameter int IDX_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    toggle_activity_monitor_if.mon   bus,
    output logic                     overrun,
    output logic                     busy
);
    localparam int TOT_W = tot_width(CNT_W, NUM_IN);
    localparam int PC_W  = $clog2(NUM_IN + 1);

    if (WIN_LEN < 1) begin : g_bad_win_len
        $error("WIN_LEN must be at least 1");
    end
    if ((2 ** CNT_W) <= WIN_LEN) begin : g_bad_cnt_w
        $error("CNT_W too narrow for WIN_LEN");
    end

    mon_state_e        state_q, state_d;
    logic [NUM_IN-1:0] prev_vec_q, prev_vec_d;
    logic              prev_out_q, prev_out_d;
    logic [TOT_W-1:0]  in_acc_q, in_acc_d;
    logic [CNT_W-1:0]  out_acc_q, out_acc_d;
    logic [CNT_W-1:0]  trans_cnt_q, trans_cnt_d;
    logic [IDX_W-1:0]  win_idx_q, win_idx_d;
    logic              rpt_valid_q, rpt_valid_d;
    logic [TOT_W-1:0]  rpt_in_q, rpt_in_d;
    logic [CNT_W-1:0]  rpt_out_q, rpt_out_d;
    logic [IDX_W-1:0]  rpt_idx_q, rpt_idx_d;
    logic              overrun_q, overrun_d;

    logic [PC_W-1:0]   pc;
    logic [TOT_W-1:0]  in_sum;
    logic [CNT_W-1:0]  out_sum;
    logic              win_close;

    popcount_n #(.N(NUM_IN), .W(PC_W)) u_popcount (
        .bits_i (bus.in_vec ^ prev_vec_q),
        .cnt_o  (pc)
    );

    assign in_sum    = in_acc_q + TOT_W'(pc);
    assign out_sum   = out_acc_q + CNT_W'(bus.in_out ^ prev_out_q);
    assign win_close = (trans_cnt_q == CNT_W'(WIN_LEN - 1));

    always_comb begin
        state_d     = state_q;
        prev_vec_d  = prev_vec_q;
        prev_out_d  = prev_out_q;
        in_acc_d    = in_acc_q;
        out_acc_d   = out_acc_q;
        trans_cnt_d = trans_cnt_q;
        win_idx_d   = win_idx_q;
        rpt_valid_d = rpt_valid_q;
        rpt_in_d    = rpt_in_q;
        rpt_out_d   = rpt_out_q;
        rpt_idx_d   = rpt_idx_q;
        overrun_d   = overrun_q;

        if (rpt_valid_q && bus.rpt_ready) begin
            rpt_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d   = ST_SEED;
                    overrun_d = 1'b0;
                    win_idx_d = '0;
                end
            end
            ST_SEED, ST_RUN: begin
                if (stop) begin
                    state_d     = ST_IDLE;
                    in_acc_d    = '0;
                    out_acc_d   = '0;
                    trans_cnt_d = '0;
                end else if (bus.in_valid) begin
                    prev_vec_d = bus.in_vec;
                    prev_out_d = bus.in_out;
                    if (state_q == ST_SEED) begin
                        state_d = ST_RUN;
                    end else if (win_close) begin
                        // A close overrides the accept above, so the new report stays valid.
                        rpt_valid_d = 1'b1;
                        rpt_in_d    = in_sum;
                        rpt_out_d   = out_sum;
                        rpt_idx_d   = win_idx_q;
                        if (rpt_valid_q && !bus.rpt_ready) begin
                            overrun_d = 1'b1;
                        end
                        in_acc_d    = '0;
                        out_acc_d   = '0;
                        trans_cnt_d = '0;
                        win_idx_d   = win_idx_q + 1'b1;
                    end else begin
                        in_acc_d    = in_sum;
                        out_acc_d   = out_sum;
                        trans_cnt_d = trans_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prev_vec_q  <= '0;
            prev_out_q  <= 1'b0;
            in_acc_q    <= '0;
            out_acc_q   <= '0;
            trans_cnt_q <= '0;
            win_idx_q   <= '0;
            rpt_valid_q <= 1'b0;
            rpt_in_q    <= '0;
            rpt_out_q   <= '0;
            rpt_idx_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_vec_q  <= prev_vec_d;
            prev_out_q  <= prev_out_d;
            in_acc_q    <= in_acc_d;
            out_acc_q   <= out_acc_d;
            trans_cnt_q <= trans_cnt_d;
            win_idx_q   <= win_idx_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_in_q    <= rpt_in_d;
            rpt_out_q   <= rpt_out_d;
            rpt_idx_q   <= rpt_idx_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.rpt_valid   = rpt_valid_q;
    assign bus.rpt_in_tog  = rpt_in_q;
    assign bus.rpt_out_tog = rpt_out_q;
    assign bus.rpt_win_idx = rpt_idx_q;
    assign overrun         = overrun_q;
    assign busy            = (state_q != ST_IDLE);
endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Directed bench for toggle_activity_monitor with a 4-transition window.
module tb_toggle_activity_monitor;
    logic clk;
    logic rst;
    logic start;
    logic stop;
    logic overrun;
    logic busy;
    int   checks;
    int   failures;

    toggle_activity_monitor_if #(.NUM_IN(4), .CNT_W(16), .IDX_W(8)) bus ();

    toggle_activity_monitor #(
        .NUM_IN  (4),
        .WIN_LEN (4),
        .CNT_W   (16),
        .IDX_W   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .bus     (bus.mon),
        .overrun (overrun),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input logic [3:0] v, input logic o);
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        bus.in_out   = o;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic chk_rpt(input string tag, input logic [31:0] in_t, input logic [31:0] out_t,
                           input logic [31:0] idx);
        chk({tag, "_valid"}, 32'(bus.rpt_valid), 32'd1);
        chk({tag, "_in_tog"}, 32'(bus.rpt_in_tog), in_t);
        chk({tag, "_out_tog"}, 32'(bus.rpt_out_tog), out_t);
        chk({tag, "_idx"}, 32'(bus.rpt_win_idx), idx);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        start         = 1'b0;
        stop          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_vec    = 4'h0;
        bus.in_out    = 1'b0;
        bus.rpt_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(bus.rpt_valid), 32'd0);
        chk("rst_in_tog", 32'(bus.rpt_in_tog), 32'd0);
        chk("rst_out_tog", 32'(bus.rpt_out_tog), 32'd0);
        chk("rst_idx", 32'(bus.rpt_win_idx), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cyc();

        // Basic window: 1 + 1 + 4 + 0 input toggles, one output toggle
        pulse_start();
        chk("seed_busy", 32'(busy), 32'd1);
        samp(4'h0, 1'b0);
        samp(4'h1, 1'b0);
        samp(4'h0, 1'b0);
        samp(4'hF, 1'b1);
        chk("pre_close_valid", 32'(bus.rpt_valid), 32'd0);
        samp(4'hF, 1'b1);
        chk_rpt("win0", 32'd6, 32'd1, 32'd0);
        chk("win0_overrun", 32'(overrun), 32'd0);

        bus.rpt_ready = 1'b1;
        cyc();
        bus.rpt_ready = 1'b0;
        chk("accept_drop", 32'(bus.rpt_valid), 32'd0);

        // Contiguous second window starting from prev = F/1
        samp(4'hE, 1'b1);
        samp(4'hE, 1'b0);
        samp(4'h6, 1'b0);
        samp(4'h6, 1'b0);
        chk_rpt("win1", 32'd2, 32'd1, 32'd1);
        cyc();
        chk_rpt("win1_hold", 32'd2, 32'd1, 32'd1);

        // Backpressure: third close overwrites the unaccepted second report
        samp(4'h7, 1'b1);
        samp(4'h7, 1'b1);
        samp(4'h7, 1'b1);
        samp(4'h7, 1'b1);
        chk_rpt("win2_over", 32'd1, 32'd1, 32'd2);
        chk("overrun_set", 32'(overrun), 32'd1);

        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_pending_valid", 32'(bus.rpt_valid), 32'd1);
        chk("stop_overrun_sticky", 32'(overrun), 32'd1);

        pulse_start();
        chk("restart_overrun_clr", 32'(overrun), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);

        // Close coincides with accepting the old report
        samp(4'h0, 1'b0);
        samp(4'h3, 1'b0);
        samp(4'h3, 1'b0);
        samp(4'h3, 1'b1);
        bus.rpt_ready = 1'b1;
        samp(4'h0, 1'b1);
        chk_rpt("close_accept", 32'd4, 32'd1, 32'd0);
        chk("close_accept_overrun", 32'(overrun), 32'd0);
        cyc();
        bus.rpt_ready = 1'b0;
        chk("drain_valid", 32'(bus.rpt_valid), 32'd0);

        // Stop mid-window with a simultaneous sample
        samp(4'h1, 1'b1);
        samp(4'h3, 1'b1);
        stop = 1'b1;
        samp(4'hF, 1'b0);
        stop = 1'b0;
        chk("midstop_busy", 32'(busy), 32'd0);
        chk("midstop_valid", 32'(bus.rpt_valid), 32'd0);
        samp(4'h5, 1'b1);
        samp(4'hA, 1'b0);
        chk("idle_ignore_busy", 32'(busy), 32'd0);
        chk("idle_ignore_valid", 32'(bus.rpt_valid), 32'd0);

        pulse_start();
        samp(4'hF, 1'b0);
        samp(4'h0, 1'b0);
        samp(4'hF, 1'b0);
        samp(4'h0, 1'b0);
        chk("reseed_no_early", 32'(bus.rpt_valid), 32'd0);
        samp(4'hF, 1'b0);
        chk_rpt("reseed_win", 32'd16, 32'd0, 32'd0);

        // Async reset in RUN with a pending report
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.rpt_valid), 32'd0);
        chk("arst_in_tog", 32'(bus.rpt_in_tog), 32'd0);
        chk("arst_idx", 32'(bus.rpt_win_idx), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        #1;
        rst = 1'b0;
        cyc();
        samp(4'h9, 1'b1);
        samp(4'h6, 1'b0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_valid", 32'(bus.rpt_valid), 32'd0);

        pulse_start();
        samp(4'h0, 1'b0);
        samp(4'h8, 1'b1);
        samp(4'hC, 1'b1);
        samp(4'hE, 1'b0);
        samp(4'hE, 1'b0);
        chk_rpt("post_rst_win", 32'd3, 32'd2, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
